// File: rtl/fib_lpm_engine.sv
// fib_lpm_engine: longest-prefix-match FIB for the NDN router.
// Prefix presence is kept as one valid bit per (length, hash bucket). Lookups
// probe from the requested length downwards until a set bit is found; length 0
// is the default route. A single FSM serialises inserts/deletes and lookups.
// Optional build macro FIB_STATS_EN adds saturating lookup/hit/insert counters.
module fib_lpm_engine #(
    parameter int PREFIX_W = 64,
    parameter int LEN_W    = 6,
    parameter int HASH_W   = 10
) (
    input  logic                clk,
    input  logic                rst,
`ifdef FIB_STATS_EN
    output logic [15:0]         stat_lookups,
    output logic [15:0]         stat_hits,
    output logic [15:0]         stat_inserts,
`endif
    input  logic                ins_valid,
    output logic                ins_ready,
    input  logic                ins_del,
    input  logic [PREFIX_W-1:0] ins_prefix,
    input  logic [LEN_W-1:0]    ins_len,
    input  logic                lu_valid,
    output logic                lu_ready,
    input  logic [PREFIX_W-1:0] lu_prefix,
    input  logic [LEN_W-1:0]    lu_len,
    output logic                res_valid,
    input  logic                res_ready,
    output logic                res_hit,
    output logic [PREFIX_W-1:0] res_prefix,
    output logic [LEN_W-1:0]    res_len
);

    localparam int NUM_LEN = 1 << LEN_W;
    localparam int NUM_BKT = 1 << HASH_W;
    localparam int NCHUNK  = (PREFIX_W + HASH_W - 1) / HASH_W;
    localparam int PAD_W   = NCHUNK * HASH_W;

    typedef enum logic [1:0] {IDLE, WRITE, PROBE, DONE} state_t;

    state_t              state_q, state_d;
    logic [PREFIX_W-1:0] opPrefix_q, opPrefix_d;
    logic [LEN_W-1:0]    opLen_q, opLen_d;
    logic                opDel_q, opDel_d;
    logic                resHit_q, resHit_d;
    logic [LEN_W-1:0]    resLen_q, resLen_d;
    logic [PREFIX_W-1:0] resPrefix_q, resPrefix_d;

    logic [NUM_BKT-1:0]  table_q [NUM_LEN];
    logic [HASH_W-1:0]   bucket;
    logic                probeBit;

    // Keep only the low 'l' bits of a prefix; a shift by the full width keeps all.
    function automatic logic [PREFIX_W-1:0] maskPrefix(input logic [PREFIX_W-1:0] p,
                                                       input logic [LEN_W-1:0]    l);
        logic [PREFIX_W-1:0] keep;
        keep = ~({PREFIX_W{1'b1}} << l);
        return p & keep;
    endfunction

    // Fold the masked prefix into HASH_W bits and mix in the length so that the
    // same bits at different lengths land in different buckets.
    function automatic logic [HASH_W-1:0] hashOf(input logic [PREFIX_W-1:0] p,
                                                 input logic [LEN_W-1:0]    l);
        logic [PAD_W-1:0]  padded;
        logic [HASH_W-1:0] h;
        padded = PAD_W'(maskPrefix(p, l));
        h      = HASH_W'(l);
        for (int c = 0; c < NCHUNK; c++) begin
            h = h ^ padded[c*HASH_W +: HASH_W];
        end
        return h;
    endfunction

    // One hash unit serves both the write and the probe, since only one runs at a time.
    assign bucket   = hashOf(opPrefix_q, opLen_q);
    assign probeBit = table_q[opLen_q][bucket];

    assign ins_ready  = (state_q == IDLE);
    assign lu_ready   = (state_q == IDLE) && !ins_valid;
    assign res_valid  = (state_q == DONE);
    assign res_hit    = resHit_q;
    assign res_len    = resLen_q;
    assign res_prefix = resPrefix_q;

    // State register; reset aborts whatever operation is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operation and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opPrefix_q  <= '0;
            opLen_q     <= '0;
            opDel_q     <= 1'b0;
            resHit_q    <= 1'b0;
            resLen_q    <= '0;
            resPrefix_q <= '0;
        end else begin
            opPrefix_q  <= opPrefix_d;
            opLen_q     <= opLen_d;
            opDel_q     <= opDel_d;
            resHit_q    <= resHit_d;
            resLen_q    <= resLen_d;
            resPrefix_q <= resPrefix_d;
        end
    end

    // Arbitration and probing: inserts win over lookups, probes walk length downwards.
    always_comb begin
        state_d     = state_q;
        opPrefix_d  = opPrefix_q;
        opLen_d     = opLen_q;
        opDel_d     = opDel_q;
        resHit_d    = resHit_q;
        resLen_d    = resLen_q;
        resPrefix_d = resPrefix_q;
        case (state_q)
            IDLE: begin
                if (ins_valid) begin
                    opPrefix_d = ins_prefix;
                    opLen_d    = ins_len;
                    opDel_d    = ins_del;
                    state_d    = WRITE;
                end else if (lu_valid) begin
                    opPrefix_d = lu_prefix;
                    opLen_d    = lu_len;
                    state_d    = PROBE;
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            PROBE: begin
                if (probeBit) begin
                    resHit_d    = 1'b1;
                    resLen_d    = opLen_q;
                    resPrefix_d = maskPrefix(opPrefix_q, opLen_q);
                    state_d     = DONE;
                end else if (opLen_q == '0) begin
                    resHit_d    = 1'b0;
                    resLen_d    = '0;
                    resPrefix_d = '0;
                    state_d     = DONE;
                end else begin
                    opLen_d = opLen_q - 1'b1;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Valid-bit table; written only in WRITE, so a later lookup sees the update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_LEN; i++) begin
                table_q[i] <= '0;
            end
        end else if (state_q == WRITE) begin
            table_q[opLen_q][bucket] <= !opDel_q;
        end
    end

`ifdef FIB_STATS_EN
    // Saturating activity counters: lookups/hits on result consumption, inserts on write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_lookups <= '0;
            stat_hits    <= '0;
            stat_inserts <= '0;
        end else begin
            if (state_q == DONE && res_ready && stat_lookups != 16'hFFFF) begin
                stat_lookups <= stat_lookups + 16'd1;
            end
            if (state_q == DONE && res_ready && resHit_q && stat_hits != 16'hFFFF) begin
                stat_hits <= stat_hits + 16'd1;
            end
            if (state_q == WRITE && !opDel_q && stat_inserts != 16'hFFFF) begin
                stat_inserts <= stat_inserts + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fib_lpm_engine.sv
// tb_fib_lpm_engine: directed bench for fib_lpm_engine with a transaction-level
// reference model (length/bucket bit table, closed-form probe latency) and a
// per-cycle compare process, plus literal expectations for the key scenarios.
module tb_fib_lpm_engine;

    localparam int PW = 64;
    localparam int LW = 6;
    localparam int HW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ins_valid = 1'b0;
    logic          ins_ready;
    logic          ins_del = 1'b0;
    logic [PW-1:0] ins_prefix = '0;
    logic [LW-1:0] ins_len = '0;
    logic          lu_valid = 1'b0;
    logic          lu_ready;
    logic [PW-1:0] lu_prefix = '0;
    logic [LW-1:0] lu_len = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic          res_hit;
    logic [PW-1:0] res_prefix;
    logic [LW-1:0] res_len;
`ifdef FIB_STATS_EN
    logic [15:0]   stat_lookups;
    logic [15:0]   stat_hits;
    logic [15:0]   stat_inserts;
`endif

    fib_lpm_engine #(.PREFIX_W(PW), .LEN_W(LW), .HASH_W(HW)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef FIB_STATS_EN
        .stat_lookups(stat_lookups),
        .stat_hits  (stat_hits),
        .stat_inserts(stat_inserts),
`endif
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .ins_del    (ins_del),
        .ins_prefix (ins_prefix),
        .ins_len    (ins_len),
        .lu_valid   (lu_valid),
        .lu_ready   (lu_ready),
        .lu_prefix  (lu_prefix),
        .lu_len     (lu_len),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_hit    (res_hit),
        .res_prefix (res_prefix),
        .res_len    (res_len)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Reference model state
    bit            mt [0:63][0:1023];
    int            mBusy = 0;
    bit            mDone = 1'b0;
    bit            mLookup = 1'b0;
    bit            mInsDel = 1'b0;
    bit            mHit = 1'b0;
    int            mLen = 0;
    logic [63:0]   mPrefix = '0;
    int            mStatL = 0;
    int            mStatH = 0;
    int            mStatI = 0;

    bit            rHit;
    int            rLen;
    int            rLat;
    logic [63:0]   rPre;

    // Bucket = XOR over set prefix bits below len of one-hot(bit index mod HW), XOR len.
    function automatic int modelHash(input logic [63:0] p, input int len);
        int h;
        h = 0;
        for (int k = 0; k < 64; k++) begin
            if (k < len && p[k]) h = h ^ (1 << (k % HW));
        end
        return h ^ len;
    endfunction

    function automatic logic [63:0] modelMask(input logic [63:0] p, input int len);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < 64; k++) begin
            if (k < len) r[k] = p[k];
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Model: advances one transaction step per clock edge from the bench-driven inputs.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                for (int l = 0; l < 64; l++)
                    for (int b = 0; b < 1024; b++) mt[l][b] = 1'b0;
                mBusy = 0; mDone = 1'b0; mLookup = 1'b0;
                mStatL = 0; mStatH = 0; mStatI = 0;
            end else if (mBusy > 0) begin
                mBusy--;
                if (mBusy == 0) begin
                    if (mLookup) mDone = 1'b1;
                    else if (!mInsDel && mStatI < 65535) mStatI++;
                end
            end else if (mDone) begin
                if (res_ready) begin
                    mDone = 1'b0;
                    if (mStatL < 65535) mStatL++;
                    if (mHit && mStatH < 65535) mStatH++;
                end
            end else if (ins_valid) begin
                mt[int'(ins_len)][modelHash(ins_prefix, int'(ins_len))] = !ins_del;
                mInsDel = ins_del;
                mLookup = 1'b0;
                mBusy   = 1;
            end else if (lu_valid) begin
                int  startLen;
                int  found;
                startLen = int'(lu_len);
                found = -1;
                for (int l = startLen; l >= 0; l--) begin
                    if (found < 0 && mt[l][modelHash(lu_prefix, l)]) found = l;
                end
                mHit    = (found >= 0);
                mLen    = mHit ? found : 0;
                mPrefix = modelMask(lu_prefix, mLen);
                mLookup = 1'b1;
                mBusy   = startLen - mLen + 1;
            end
        end
    end

    // Compare DUT against the model on every falling edge outside reset.
    initial begin
        forever begin
            bit idle;
            @(negedge clk);
            if (!rst) begin
                idle = (mBusy == 0) && !mDone;
                checkOutput("ins_ready", ins_ready, idle);
                checkOutput("lu_ready", lu_ready, idle && !ins_valid);
                checkOutput("res_valid", res_valid, mDone);
                if (mDone) begin
                    checkOutput("res_hit", res_hit, mHit);
                    checkOutput("res_len", res_len, mLen);
                    checkOutput("res_prefix", res_prefix, mPrefix);
                end
`ifdef FIB_STATS_EN
                checkOutput("stat_lookups", stat_lookups, mStatL);
                checkOutput("stat_hits", stat_hits, mStatH);
                checkOutput("stat_inserts", stat_inserts, mStatI);
`endif
            end
        end
    end

    // Wait for a result, capture it, optionally stall the consumer, then consume it.
    task automatic waitResult(input int hold, output bit hit, output int len,
                              output logic [63:0] pre, output int lat);
        lat = 0;
        hit = 1'b0; len = 0; pre = '0;
        do begin
            @(negedge clk);
            if (!res_valid) lat++;
        end while (!res_valid && lat < 200);
        if (!res_valid) begin
            checkOutput("result timeout", 64'd0, 64'd1);
            return;
        end
        hit = res_hit;
        len = int'(res_len);
        pre = res_prefix;
        @(posedge clk); #1;
        if (hold > 0) begin
            lu_valid  = 1'b1;
            lu_prefix = 64'hDEAD;
            lu_len    = 6'd3;
            repeat (hold) @(posedge clk);
            #1;
            lu_valid = 1'b0;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    // Drive one insert/delete or lookup through its handshake; lookups also return the result.
    task automatic applyStimulus(input bit isLookup, input logic [63:0] p, input int len,
                                 input bit del, input int hold, output bit hit,
                                 output int rlen, output logic [63:0] rpre, output int lat);
        int guard;
        hit = 1'b0; rlen = 0; rpre = '0; lat = 0;
        @(posedge clk); #1;
        if (isLookup) begin
            lu_valid = 1'b1; lu_prefix = p; lu_len = LW'(len);
        end else begin
            ins_valid = 1'b1; ins_prefix = p; ins_len = LW'(len); ins_del = del;
        end
        guard = 0;
        @(negedge clk);
        while (!(isLookup ? lu_ready : ins_ready) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!(isLookup ? lu_ready : ins_ready)) begin
            checkOutput("accept timeout", 64'd0, 64'd1);
            lu_valid = 1'b0; ins_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        lu_valid = 1'b0; ins_valid = 1'b0; ins_del = 1'b0;
        if (isLookup) waitResult(hold, hit, rlen, rpre, lat);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int guard;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset ins_ready", ins_ready, 1'b1);
        checkOutput("reset lu_ready", lu_ready, 1'b1);
        checkOutput("reset res_valid", res_valid, 1'b0);
        checkOutput("model hash pin", modelHash(64'hABCD, 16), 64'h3F7);

        // Insert 0xABCD/16: busy exactly one cycle
        applyStimulus(1'b0, 64'hABCD, 16, 1'b0, 0, rHit, rLen, rPre, rLat);
        @(negedge clk);
        checkOutput("insert busy", ins_ready, 1'b0);
        @(negedge clk);
        checkOutput("insert ready again", ins_ready, 1'b1);

        // Exact-length lookup
        applyStimulus(1'b1, 64'hABCD, 16, 1'b0, 0, rHit, rLen, rPre, rLat);
        checkOutput("exact hit", rHit, 1'b1);
        checkOutput("exact len", rLen, 16);
        checkOutput("exact prefix", rPre, 64'hABCD);
        checkOutput("exact probes", rLat, 1);

        // Longer name falls back to the /16 entry
        applyStimulus(1'b1, 64'h12ABCD, 24, 1'b0, 0, rHit, rLen, rPre, rLat);
        checkOutput("lpm hit", rHit, 1'b1);
        checkOutput("lpm len", rLen, 16);
        checkOutput("lpm prefix", rPre, 64'hABCD);
        checkOutput("lpm probes", rLat, 9);

        // Delete then look up: miss
        applyStimulus(1'b0, 64'hABCD, 16, 1'b1, 0, rHit, rLen, rPre, rLat);
        applyStimulus(1'b1, 64'hABCD, 16, 1'b0, 0, rHit, rLen, rPre, rLat);
        checkOutput("deleted hit", rHit, 1'b0);
        checkOutput("deleted len", rLen, 0);
        checkOutput("deleted probes", rLat, 17);

        // Empty table, start length 5
        applyStimulus(1'b1, 64'h5555, 5, 1'b0, 0, rHit, rLen, rPre, rLat);
        checkOutput("empty hit", rHit, 1'b0);
        checkOutput("empty len", rLen, 0);
        checkOutput("empty prefix", rPre, 64'h0);
        checkOutput("empty probes", rLat, 6);

        // Default route at length 0
        applyStimulus(1'b0, 64'hFFFF, 0, 1'b0, 0, rHit, rLen, rPre, rLat);
        applyStimulus(1'b1, 64'h1234, 8, 1'b0, 0, rHit, rLen, rPre, rLat);
        checkOutput("default hit", rHit, 1'b1);
        checkOutput("default len", rLen, 0);
        checkOutput("default prefix", rPre, 64'h0);
        checkOutput("default probes", rLat, 9);

        // Same-cycle insert and lookup: insert first, lookup sees it
        @(posedge clk); #1;
        ins_valid = 1'b1; ins_prefix = 64'h77; ins_len = 6'd8; ins_del = 1'b0;
        lu_valid  = 1'b1; lu_prefix  = 64'hFF77; lu_len  = 6'd8;
        @(negedge clk);
        checkOutput("collision lu_ready", lu_ready, 1'b0);
        checkOutput("collision ins_ready", ins_ready, 1'b1);
        @(posedge clk); #1;
        ins_valid = 1'b0;
        guard = 0;
        @(negedge clk);
        while (!lu_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("collision lookup accepted", lu_ready, 1'b1);
        @(posedge clk); #1;
        lu_valid = 1'b0;
        waitResult(0, rHit, rLen, rPre, rLat);
        checkOutput("collision hit", rHit, 1'b1);
        checkOutput("collision len", rLen, 8);
        checkOutput("collision prefix", rPre, 64'h77);

        // Consumer stalls 5 cycles with a competing lookup pending
        applyStimulus(1'b1, 64'h1077, 8, 1'b0, 5, rHit, rLen, rPre, rLat);
        checkOutput("stall hit", rHit, 1'b1);
        checkOutput("stall len", rLen, 8);

        // Reset in the middle of a long probe
        @(posedge clk); #1;
        lu_valid = 1'b1; lu_prefix = 64'h0; lu_len = 6'd40;
        @(negedge clk);
        @(posedge clk); #1;
        lu_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("midreset res_valid", res_valid, 1'b0);
        checkOutput("midreset ins_ready", ins_ready, 1'b1);
        checkOutput("midreset lu_ready", lu_ready, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        applyStimulus(1'b1, 64'h77, 8, 1'b0, 0, rHit, rLen, rPre, rLat);
        checkOutput("cleared hit", rHit, 1'b0);
        checkOutput("cleared probes", rLat, 9);

        // Two hits after re-insert: 3 lookups, 2 hits since reset
        applyStimulus(1'b0, 64'h77, 8, 1'b0, 0, rHit, rLen, rPre, rLat);
        applyStimulus(1'b1, 64'h77, 8, 1'b0, 0, rHit, rLen, rPre, rLat);
        checkOutput("reinsert hit A", rHit, 1'b1);
        applyStimulus(1'b1, 64'hA5A5_0077, 20, 1'b0, 0, rHit, rLen, rPre, rLat);
        checkOutput("reinsert hit B", rHit, 1'b1);
        checkOutput("reinsert len B", rLen, 8);
        checkOutput("reinsert probes B", rLat, 13);
`ifdef FIB_STATS_EN
        checkOutput("stats lookups", stat_lookups, 16'd3);
        checkOutput("stats hits", stat_hits, 16'd2);
        checkOutput("stats inserts", stat_inserts, 16'd1);
`endif

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
